// File: rtl/microcode_controller.sv
// -----------------------------------------------------------------------------
// microcode_controller
//
// Sequences multi-step micro-programs for the V-CORE control path. Decode
// offers an opcode over a valid/ready handshake. The controller maps the
// opcode to a micro-ROM start address and a last address. It then steps the
// micro-address once per unstalled cycle and signals completion with a
// one-cycle done pulse.
//
// Optional build macro: MSEQ_PERF_EN
//   defined     : instr_count counts retired instructions and saturates at
//                 0xFFFF. Only reset clears it.
//   not defined : instr_count is the constant 0 and no counter flops exist.
//
// Parameters:
//   UADDR_W   micro-address width (>= 4)
//   OPCODE_W  opcode width
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   op_valid     opcode offered by decode
//   opcode       instruction opcode (sampled only on acceptance)
//   op_ready     controller can accept an opcode (IDLE)
//   stall        datapath hold; freezes sequencing in EXEC
//   uaddr        current micro-address into the micro-ROM
//   uvalid       uaddr is a live micro-op this cycle
//   busy         instruction in progress (EXEC or DONE)
//   done         1-cycle pulse: instruction retired
//   illegal      1-cycle pulse with done: retired opcode was unmapped
//   instr_count  retired-instruction counter
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an opcode; op_ready=1, uaddr=0
// EXEC  | presenting micro-ops start..last, one step per unstalled cycle
// DONE  | single retire cycle; done (and illegal if unmapped) pulses
// -----------------------------------------------------------------------------
module microcode_controller #(
    parameter int UADDR_W  = 4,
    parameter int OPCODE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                op_ready,
    input  logic                stall,
    output logic [UADDR_W-1:0]  uaddr,
    output logic                uvalid,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [15:0]         instr_count
);

    if (UADDR_W < 4) begin : g_bad_width
        $error("microcode_controller: UADDR_W must be 4 or greater");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [UADDR_W-1:0]   uaddr_q, uaddr_d;
    logic [UADDR_W-1:0]   last_q, last_d;
    logic                 illegal_q, illegal_d;

    logic [UADDR_W-1:0]   dec_start;
    logic [UADDR_W-1:0]   dec_last;
    logic                 dec_illegal;

    // Opcode map. Unmapped opcodes run one micro-op at the all-ones address
    // so that the micro-ROM can hold a trap entry there.
    always_comb begin
        dec_start   = '1;
        dec_last    = '1;
        dec_illegal = 1'b1;
        case (opcode)
            OPCODE_W'(1): begin
                dec_start   = UADDR_W'(0);
                dec_last    = UADDR_W'(1);
                dec_illegal = 1'b0;
            end
            OPCODE_W'(2): begin
                dec_start   = UADDR_W'(2);
                dec_last    = UADDR_W'(4);
                dec_illegal = 1'b0;
            end
            OPCODE_W'(3): begin
                dec_start   = UADDR_W'(5);
                dec_last    = UADDR_W'(8);
                dec_illegal = 1'b0;
            end
            default: begin
                dec_start   = '1;
                dec_last    = '1;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            uaddr_q   <= '0;
            last_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uaddr_q   <= uaddr_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        uaddr_d   = uaddr_q;
        last_d    = last_q;
        illegal_d = illegal_q;
        op_ready  = 1'b0;
        uvalid    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                uaddr_d  = '0;
                // stall has no effect on acceptance
                if (op_valid) begin
                    state_d   = S_EXEC;
                    uaddr_d   = dec_start;
                    last_d    = dec_last;
                    illegal_d = dec_illegal;
                end
            end
            S_EXEC: begin
                busy   = 1'b1;
                uvalid = 1'b1;
                if (!stall) begin
                    if (uaddr_q == last_q) begin
                        state_d = S_DONE;
                        uaddr_d = '0;
                    end else begin
                        // last never exceeds all-ones, so this never carries out
                        uaddr_d = uaddr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                illegal = illegal_q;
                state_d = S_IDLE;
                uaddr_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                uaddr_d = '0;
            end
        endcase
    end

    assign uaddr = uaddr_q;

`ifdef MSEQ_PERF_EN
    logic [15:0] instr_count_q;

    // Written only on a retire cycle, so the value holds between retirements.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= '0;
        end else if (done && (instr_count_q != 16'hFFFF)) begin
            instr_count_q <= instr_count_q + 16'd1;
        end
    end

    assign instr_count = instr_count_q;
`else
    assign instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_microcode_controller.sv
// -----------------------------------------------------------------------------
// tb_microcode_controller
//
// Self-checking bench for microcode_controller. A behavioural model holds the
// pending micro-ops of the running instruction as a queue of addresses. A
// compare process checks every DUT output against this model on each falling
// edge. Directed scenarios also check observed traces against hand-written
// literal values. Set MSEQ_PERF_EN at compile time to cover the counter build.
// -----------------------------------------------------------------------------
module tb_microcode_controller;

    localparam int UADDR_W  = 4;
    localparam int OPCODE_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                op_valid;
    logic [OPCODE_W-1:0] opcode;
    logic                op_ready;
    logic                stall;
    logic [UADDR_W-1:0]  uaddr;
    logic                uvalid;
    logic                busy;
    logic                done;
    logic                illegal;
    logic [15:0]         instr_count;

    microcode_controller #(.UADDR_W(UADDR_W), .OPCODE_W(OPCODE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .opcode      (opcode),
        .op_ready    (op_ready),
        .stall       (stall),
        .uaddr       (uaddr),
        .uvalid      (uvalid),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        cyc = 0;
    int        m_ops[$];
    bit        m_retire = 0;
    bit        m_ill    = 0;
    bit        m_ill_pending = 0;
    int        m_cnt    = 0;

    function automatic void decode(input logic [OPCODE_W-1:0] op,
                                   output int start, output int len, output bit ill);
        ill = 0;
        case (op)
            8'h01:   begin start = 0;  len = 2; end
            8'h02:   begin start = 2;  len = 3; end
            8'h03:   begin start = 5;  len = 4; end
            default: begin start = 15; len = 1; ill = 1; end
        endcase
    endfunction

    always @(posedge clk) begin
        int s, l;
        bit il;
        cyc++;
        if (reset) begin
            m_ops.delete();
            m_retire = 0;
            m_ill    = 0;
            m_cnt    = 0;
        end else if (m_retire) begin
            m_retire = 0;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else if (m_ops.size() != 0) begin
            if (!stall) begin
                void'(m_ops.pop_front());
                if (m_ops.size() == 0) begin
                    m_retire = 1;
                    m_ill    = m_ill_pending;
                end
            end
        end else if (op_valid) begin
            decode(opcode, s, l, il);
            for (int i = 0; i < l; i++) m_ops.push_back(s + i);
            m_ill_pending = il;
        end
    end

    // ---------------- compare + observation ----------------
    bit chk_en  = 0;
    bit prev_uv = 0;
    int trace[$];
    int first_cyc[$];
    int done_cyc[$];
    int ill_cyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit exp_uv   = (m_ops.size() != 0);
            automatic bit exp_busy = exp_uv || m_retire;
            check("uvalid",   uvalid,   exp_uv);
            check("uaddr",    uaddr,    exp_uv ? m_ops[0] : 0);
            check("done",     done,     m_retire);
            check("illegal",  illegal,  m_retire && m_ill);
            check("busy",     busy,     exp_busy);
            check("op_ready", op_ready, !exp_busy);
`ifdef MSEQ_PERF_EN
            check("instr_count", instr_count, m_cnt);
`else
            check("instr_count", instr_count, 0);
`endif
            if (uvalid) trace.push_back(int'(uaddr));
            if (uvalid && !prev_uv) first_cyc.push_back(cyc);
            if (done) done_cyc.push_back(cyc);
            if (illegal) ill_cyc.push_back(cyc);
            prev_uv = uvalid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        trace.delete();
        first_cyc.delete();
        done_cyc.delete();
        ill_cyc.delete();
    endtask

    task automatic check_trace(input string name, input int exp[$]);
        check({name, "_len"}, trace.size(), exp.size());
        if (trace.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) check(name, trace[i], exp[i]);
        end
    endtask

    task automatic issue(input logic [7:0] op);
        op_valid = 1'b1;
        opcode   = op;
        step(1);
        op_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        opcode   = '0;
        stall    = 1'b0;

        // reset
        step(1);
        chk_en = 1;
        step(2);
        check("rst_op_ready", op_ready, 1);
        check("rst_uvalid",   uvalid,   0);
        check("rst_uaddr",    uaddr,    0);
        check("rst_count",    instr_count, 0);
        reset = 1'b0;
        step(2);

        // opcode 0x01, no stall
        clear_obs();
        issue(8'h01);
        step(5);
        check_trace("tr01", '{0, 1});
        check("d01_cnt", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && first_cyc.size() == 1)
            check("d01_lat", done_cyc[0] - first_cyc[0], 2);
        check("i01_cnt", ill_cyc.size(), 0);

        // opcode 0x03 with a two-cycle stall on uaddr 6
        clear_obs();
        issue(8'h03);           // uaddr 5 now visible
        step(1);                // uaddr 6 visible
        stall = 1'b1;
        step(2);
        stall = 1'b0;
        step(6);
        check_trace("tr03", '{5, 6, 6, 6, 7, 8});
        check("d03_cnt", done_cyc.size(), 1);
        if (done_cyc.size() == 1 && first_cyc.size() == 1)
            check("d03_lat", done_cyc[0] - first_cyc[0], 6);

        // stall while idle does not block acceptance; unmapped opcode 0x7F
        clear_obs();
        stall = 1'b1;
        op_valid = 1'b1;
        opcode   = 8'h7F;
        step(1);
        op_valid = 1'b0;
        stall    = 1'b0;
        step(4);
        check_trace("tr7f", '{15});
        check("i7f_cnt", ill_cyc.size(), 1);
        check("d7f_cnt", done_cyc.size(), 1);
        if (ill_cyc.size() == 1 && done_cyc.size() == 1)
            check("i7f_with_done", ill_cyc[0], done_cyc[0]);
`ifdef MSEQ_PERF_EN
        check("count_3", instr_count, 3);
`endif

        // opcode 0x02 aborted by reset while uaddr=3
        clear_obs();
        issue(8'h02);           // uaddr 2
        step(1);                // uaddr 3
        reset = 1'b1;
        step(1);
        check("abort_uvalid",   uvalid,   0);
        check("abort_uaddr",    uaddr,    0);
        check("abort_op_ready", op_ready, 1);
        reset = 1'b0;
        step(4);
        check_trace("tr_abort", '{2, 3});
        check("abort_done", done_cyc.size(), 0);

        // op_valid together with reset: dropped
        clear_obs();
        reset    = 1'b1;
        op_valid = 1'b1;
        opcode   = 8'h01;
        step(1);
        reset    = 1'b0;
        op_valid = 1'b0;
        step(4);
        check("rstvalid_trace", trace.size(), 0);

        // op_valid held: 0x01 then 0x02, opcode changed during EXEC
        clear_obs();
        op_valid = 1'b1;
        opcode   = 8'h01;
        step(1);                // first accepted, uaddr 0 visible
        opcode   = 8'h02;
        step(4);                // second accepted at the 4th edge
        op_valid = 1'b0;
        opcode   = 8'h03;       // must not affect the running sequence
        step(8);
        check_trace("tr_b2b", '{0, 1, 2, 3, 4});
        check("b2b_starts", first_cyc.size(), 2);
        if (first_cyc.size() == 2)
            check("b2b_gap", first_cyc[1] - first_cyc[0], 4);
        check("b2b_done", done_cyc.size(), 2);

`ifdef MSEQ_PERF_EN
        check("count_after_reset", instr_count, 2);
        force dut.instr_count_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        step(1);
        issue(8'h01);
        step(5);
        check("count_ffff", instr_count, 16'hFFFF);
        issue(8'h44);
        step(4);
        check("count_sat", instr_count, 16'hFFFF);
`else
        issue(8'h01);
        step(5);
        check("count_tied", instr_count, 0);
`endif

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microcode_controller.md
Name: microcode_controller

Overview:
Sequences multi-step micro-programs for the V-CORE control path. Accepts an opcode over a valid/ready handshake and maps it to a micro-ROM start address and length. Steps the micro-address once per unstalled cycle, then signals completion. Sits between instruction decode and the micro-ROM/datapath control-word fetch.

Parameters:
UADDR_W, 4, micro-address width; must be 4 or greater.
OPCODE_W, 8, opcode width.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
op_valid  input  1  opcode offered by decode
opcode  input  OPCODE_W  instruction opcode
op_ready  output  1  controller can accept an opcode
stall  input  1  datapath hold; freezes sequencing
uaddr  output  UADDR_W  current micro-address into the micro-ROM
uvalid  output  1  uaddr is a live micro-op this cycle
busy  output  1  instruction in progress (EXEC or DONE)
done  output  1  1-cycle pulse: instruction retired
illegal  output  1  1-cycle pulse with done: retired opcode was unmapped
instr_count  output  16  retired-instruction counter (see Optional Feature)

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: state IDLE, uaddr=0, uvalid=0, busy=0, done=0, illegal=0, instr_count=0.
- Reset has priority over all inputs. Reset mid-EXEC aborts the instruction: no done pulse, and the controller returns to IDLE.
- Decode table, giving start address and length:
  - 0x01: start 0, length 2 (uaddr 0,1).
  - 0x02: start 2, length 3 (uaddr 2,3,4).
  - 0x03: start 5, length 4 (uaddr 5..8).
  - Any other opcode: start = all-ones (15), length 1; the illegal flag is latched.
- IDLE: op_ready=1, uvalid=0, busy=0, uaddr=0.
  - On op_valid & op_ready: latch start address, last address (start+length-1) and illegal flag; go to EXEC.
  - stall is ignored in IDLE; acceptance is not gated by stall.
- EXEC: op_ready=0, busy=1, uvalid=1.
  - First EXEC cycle presents uaddr=start.
  - If stall=1: uaddr and state hold, and uvalid stays 1 (the same micro-op is re-presented).
  - If stall=0 and uaddr != last: uaddr increments by 1 next cycle.
  - If stall=0 and uaddr == last: go to DONE.
- DONE: exactly one cycle. done=1, illegal=latched flag, uvalid=0, busy=1, op_ready=0, uaddr returns to 0. Next state is IDLE.
- Timing with no stalls: accept at cycle T; micro-ops at T+1..T+len; done at T+len+1; op_ready again at T+len+2. The minimum back-to-back issue interval is len+2 cycles.
- uaddr never wraps: the last address is at most 15, so no carry out of UADDR_W.
- op_valid held high while op_ready=0 is not consumed. The opcode input is sampled only on the acceptance cycle; later changes have no effect on the running sequence.
- Asserting op_valid together with reset: reset wins and the opcode is dropped.

Optional Feature:
Macro MSEQ_PERF_EN.
- Defined: instr_count increments by 1 on every done pulse (legal or illegal). It saturates at 0xFFFF and clears only on reset.
- Not defined: instr_count is tied to constant 0 and no counter flops are synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then opcode 0x01 accepted at T with no stall -> uvalid with uaddr 0,1 at T+1,T+2; done=1, illegal=0 at T+3; op_ready=1 at T+4.
- Opcode 0x03 with stall=1 during the cycle uaddr=6 for 2 cycles -> sequence 5,6,6,6,7,8; done exactly once, 1 cycle after uaddr=8 issues.
- Opcode 0x7F -> single micro-op uaddr=15; then done=1 and illegal=1 in the same cycle; no other illegal pulses.
- Opcode 0x02 accepted; assert reset while uaddr=3 -> next cycle IDLE, uaddr=0, uvalid=0, no done pulse, op_ready=1.
- op_valid held high continuously with opcodes 0x01 then 0x02 -> second accepted only when op_ready returns (4 cycles after first acceptance); opcode changes during EXEC do not alter the sequence.
- With MSEQ_PERF_EN: 3 instructions retired -> instr_count=3; counter preloaded/forced near 0xFFFF saturates at 0xFFFF. Without the macro: instr_count stays 0.
